// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V fetch definitions: XLEN, NOP encoding, fetch FSM states, buffer entry
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/rv_if_fifo.sv
// rtl/rv_if_fifo.sv - synchronous fetch buffer with push/pop/flush and full/empty/count
module rv_if_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot, so a full buffer may still accept
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    // storage array; no reset needed, occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr] <= wdata;
        end
    end

    // pointers and occupancy; flush discards everything held
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv_if_stage.sv
// rtl/rv_if_stage.sv - instruction fetch stage with fetch buffer and IF/ID register; RV_IF_PERF_CNT_EN adds stall/bubble counters
module rv_if_stage import rv_pkg::*; #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_write_i,
    input  logic        IF_ID_write_i,
    input  logic        IF_flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ID_pc_o,
    output logic [31:0] ID_instr_o,
    output logic        ID_valid_o
`ifdef RV_IF_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    if_state_e       state;
    if_state_e       state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_next;

    logic            redirect;
    logic            grant;
    logic            resp;
    logic            id_load;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            has_room;

    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    assign redirect   = IF_flush_i | branch_taken_i;
    // only one request is ever outstanding and none is while in REQ, so a free slot suffices
    assign has_room   = (fifo_count < CW'(BUF_DEPTH));
    assign imem_req_o = (state == REQ) & PC_write_i & has_room;
    assign imem_addr_o = fetch_pc;
    assign grant      = imem_req_o & imem_gnt_i;

    // fetch_pc was advanced at grant and cannot move while waiting, so the request PC is one word back
    assign push_entry.pc    = fetch_pc - 32'd4;
    assign push_entry.instr = imem_rdata_i;

    assign resp    = (state == WAIT) & imem_rvalid_i & ~redirect;
    assign id_load = IF_ID_write_i & ~redirect;
    // an empty buffer lets a fresh response go straight into IF/ID for 2-cycle latency
    assign bypass  = resp & fifo_empty & id_load;
    assign pop     = id_load & ~fifo_empty;
    assign push    = resp & ~bypass & (~fifo_full | pop);

    rv_if_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // fetch FSM next state and next fetch PC; redirect always wins the PC
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (grant) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_next = REQ;
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_next = branch_target_i;
        end
    end

    // FSM state and fetch PC registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    // IF/ID register: redirect squashes, stall holds, otherwise take buffer head, bypass or a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ID_pc_o    <= '0;
            ID_instr_o <= NOP_INSTR;
            ID_valid_o <= 1'b0;
        end else if (redirect) begin
            ID_instr_o <= NOP_INSTR;
            ID_valid_o <= 1'b0;
        end else if (IF_ID_write_i) begin
            if (!fifo_empty) begin
                ID_pc_o    <= head_entry.pc;
                ID_instr_o <= head_entry.instr;
                ID_valid_o <= 1'b1;
            end else if (bypass) begin
                ID_pc_o    <= push_entry.pc;
                ID_instr_o <= push_entry.instr;
                ID_valid_o <= 1'b1;
            end else begin
                ID_instr_o <= NOP_INSTR;
                ID_valid_o <= 1'b0;
            end
        end
    end

`ifdef RV_IF_PERF_CNT_EN
    logic id_bubble;

    assign id_bubble = redirect | (IF_ID_write_i & fifo_empty & ~bypass);

    // decode stall and bubble counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (!IF_ID_write_i) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (id_bubble) begin
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/rv_if_stage.md
RV_IF_STAGE -- requirements
Module: rv_if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning fetch-buffer entries (power of two, 2..8).
REQ-003 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset, synchronous, active-high (one clock; polarity and synchronicity fixed).
REQ-004 SHALL have ports: PC_write_i in 1, 0 = hold PC, issue no new fetch; IF_ID_write_i in 1, 0 = hold IF/ID outputs.
REQ-005 SHALL have ports: IF_flush_i in 1, squash fetched instrs; branch_taken_i in 1, redirect; branch_target_i in 32, redirect PC.
REQ-006 SHALL have ports: imem_req_o out 1, imem_addr_o out 32, imem_gnt_i in 1, imem_rvalid_i in 1, imem_rdata_i in 32 (instruction memory, one outstanding request max).
REQ-007 SHALL have ports: ID_pc_o out 32, ID_instr_o out 32, ID_valid_o out 1 (IF/ID register to decode and hazard detection).

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT, DROP; reset enters IDLE, IDLE -> REQ next cycle unconditionally.
REQ-009 SHALL assert imem_req_o in REQ only when PC_write_i=1 and buffer free entries minus outstanding requests >= 1; imem_addr_o = fetch PC.
REQ-010 SHALL, on imem_req_o & imem_gnt_i, advance fetch PC by 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0) and go to WAIT.
REQ-011 SHALL, in WAIT on imem_rvalid_i, push {pc, imem_rdata_i} into buffer and return to REQ; response and new request not in same cycle.
REQ-012 SHALL hold imem_addr_o and imem_req_o stable while imem_req_o=1 and imem_gnt_i=0, unless redirect.
REQ-013 SHALL treat redirect = IF_flush_i | branch_taken_i; on redirect: fetch PC <= branch_target_i, buffer emptied, ID_valid_o <= 0, ID_instr_o <= 32'h0000_0013.
REQ-014 SHALL, on redirect in WAIT without same-cycle rvalid, go to DROP and discard next response; DROP -> REQ on imem_rvalid_i.
REQ-015 SHALL, on redirect while in REQ with grant same cycle, discard that request's response via DROP.
REQ-016 SHALL give redirect priority over IF_ID_write_i=0 and PC_write_i=0.
REQ-017 SHALL, when IF_ID_write_i=1 and no redirect, load IF/ID from buffer head (pop) with ID_valid_o=1 if nonempty, else ID_valid_o=0, ID_instr_o=NOP.
REQ-018 SHALL, when IF_ID_write_i=0, hold ID_pc_o/ID_instr_o/ID_valid_o and not pop.
REQ-019 SHALL support simultaneous push and pop when buffer full; never push when full (guaranteed by REQ-009).
REQ-020 SHALL achieve 2-cycle best-case latency: grant cycle N, rvalid N+1, ID_valid_o at N+2 (bypass when buffer empty permitted only if result identical).

Reset
REQ-021 SHALL on rst: fetch PC=RESET_PC, FSM=IDLE, buffer empty, imem_req_o=0, imem_addr_o=RESET_PC, ID_pc_o=0, ID_instr_o=32'h0000_0013, ID_valid_o=0.
REQ-022 SHALL, on rst mid-transaction, abandon outstanding request; any rvalid in first two cycles after rst is ignored.

Configuration
REQ-023 SHALL with RV_IF_PERF_CNT_EN defined add outputs stall_cnt_o (32) counting cycles with IF_ID_write_i=0, and bubble_cnt_o (32) counting cycles IF/ID loaded with ID_valid_o=0; both reset to 0, wrap at 2^32.
REQ-024 SHALL without RV_IF_PERF_CNT_EN have neither port nor counter logic.

Structure
REQ-025 SHALL take NOP encoding 32'h0000_0013, XLEN=32 and FSM state enum from shared package rv_pkg.
REQ-026 SHALL implement buffer as sub-module rv_if_fifo (synchronous, BUF_DEPTH entries of 64 bits, push/pop/flush, full/empty/count).

Verification
REQ-027 Reset release, gnt=1, rvalid one cycle later, rdata=32'h0010_0093 -> addr 0x0 issued cycle 1, ID_instr_o=32'h0010_0093, ID_pc_o=0, ID_valid_o=1 at cycle 3.
REQ-028 IF_ID_write_i=0 for 4 cycles, memory always ready -> exactly BUF_DEPTH=2 requests outstanding/buffered, imem_req_o=0 afterward, no instruction lost or duplicated.
REQ-029 branch_taken_i=1, target 32'h0000_0100, while in WAIT -> stale response dropped, next imem_addr_o=0x100, ID_valid_o=0 bubble next cycle.
REQ-030 IF_flush_i=1 and IF_ID_write_i=0 same cycle -> buffer flushed, ID_valid_o=0, ID_instr_o=NOP.
REQ-031 RESET_PC=32'hFFFF_FFFC, two fetches -> second imem_addr_o=32'h0000_0000.
REQ-032 RV_IF_PERF_CNT_EN defined, 5 stall cycles then 1 empty-buffer load -> stall_cnt_o=5, bubble_cnt_o=1.
